// File: rtl/adder_word_sequencer.sv
// adder_word_sequencer: computes N*WORDS-bit sums on one external N-bit adder, one slice per cycle, LSB first.
// Optional macro SEQ_SIGNED_OVF_EN adds the out_ovf signed-overflow output.
module adder_word_sequencer #(
  parameter int N = 16,
  parameter int WORDS = 4,
  localparam int W = N * WORDS,
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic [N-1:0] adder_a,
  output logic [N-1:0] adder_b,
  output logic         adder_cin,
  input  logic [N-1:0] adder_s,
  input  logic         adder_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy
`ifdef SEQ_SIGNED_OVF_EN
  , output logic       out_ovf
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic          r_cout;
  logic          w_run, w_last, w_accept;
  assign w_run    = r_state == RUN;
  assign w_last   = r_idx == IW'(WORDS - 1);
  assign w_accept = r_state == IDLE && in_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next    = w_accept ? RUN :
                (w_run && w_last) ? DONE :
                (r_state == DONE && out_ready) ? IDLE : r_state;
    in_ready  = r_state == IDLE && !rst;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
    // Adder inputs are parked at zero outside RUN to keep the shared adder quiet.
    adder_a   = w_run ? r_a[r_idx*N +: N] : '0;
    adder_b   = w_run ? r_b[r_idx*N +: N] : '0;
    adder_cin = w_run & r_carry;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_carry <= in_cin;
      r_idx   <= '0;
    end else if (w_run) begin
      r_sum[r_idx*N +: N] <= adder_s;
      r_carry <= adder_cout;
      if (w_last) r_cout <= adder_cout;
      else        r_idx  <= r_idx + IW'(1);
    end
  end
  assign out_sum  = r_sum;
  assign out_cout = r_cout;
`ifdef SEQ_SIGNED_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_ovf <= 1'b0;
    else if (w_run && w_last) r_ovf <= (r_a[W-1] == r_b[W-1]) && (adder_s[N-1] != r_a[W-1]);
  end
  assign out_ovf = r_ovf;
`endif
endmodule
